// File: rtl/ddr_out_sequencer.sv
// rtl/ddr_out_sequencer.sv - DDR output pad cell sequencer
// Frames each burst with lead/trail idle cycles and parks the cell via DR/DS on return to idle.
module ddr_out_sequencer #(
  parameter int   WIDTH    = 8,
  parameter int   LEAD     = 1,
  parameter int   TRAIL    = 1,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] DIN,
  input  logic             VALID,
  output logic             READY,
  input  logic             ABORT,
  output logic             BUSY,
  output logic             D0,
  output logic             D1,
  output logic             CE,
  output logic             DR,
  output logic             DS,
  output logic             T
);

  localparam int PAIRS = WIDTH / 2;
  localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [3:0]    LEAD_INIT  = (LEAD > 0) ? 4'(LEAD - 1) : 4'd0;
  localparam logic [3:0]    TRAIL_INIT = (TRAIL > 0) ? 4'(TRAIL - 1) : 4'd0;
  localparam logic [PW-1:0] LAST_PAIR  = PW'(PAIRS - 1);

  typedef enum logic [2:0] {IDLE, LEADS, SHIFT, TRAILS, PARK} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PW-1:0]    pair_q, pair_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic t_q, ce_q, d0_q, d1_q, dr_q, ds_q, busy_q;
  logic t_d, ce_d, d0_d, d1_d, dr_d, ds_d, busy_d;
  logic last_pair, accept;

  assign last_pair = (pair_q == LAST_PAIR);
  // READY is the only combinational output; abort suppresses the reload handshake in SHIFT.
  assign READY  = (state_q == IDLE) || ((state_q == SHIFT) && last_pair && !ABORT);
  assign accept = VALID && READY;

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pair_q  <= '0;
      sh_q    <= '0;
      t_q     <= 1'b1;
      ce_q    <= 1'b0;
      d0_q    <= 1'b0;
      d1_q    <= 1'b0;
      dr_q    <= 1'b0;
      ds_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pair_q  <= pair_d;
      sh_q    <= sh_d;
      t_q     <= t_d;
      ce_q    <= ce_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      dr_q    <= dr_d;
      ds_q    <= ds_d;
      busy_q  <= busy_d;
    end
  end

  // sh_q always holds the pair being presented in its top two bits while in SHIFT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pair_d  = pair_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d   = DIN;
          pair_d = '0;
          cnt_d  = LEAD_INIT;
          state_d = (LEAD == 0) ? SHIFT : LEADS;
        end
      end
      LEADS: begin
        if (ABORT) begin
          state_d = PARK;
          sh_d    = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = SHIFT;
          pair_d  = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SHIFT: begin
        if (ABORT) begin
          state_d = PARK;
          sh_d    = '0;
        end else if (last_pair) begin
          if (accept) begin
            sh_d   = DIN;
            pair_d = '0;
          end else begin
            cnt_d   = TRAIL_INIT;
            state_d = (TRAIL == 0) ? PARK : TRAILS;
          end
        end else begin
          sh_d   = sh_q << 2;
          pair_d = pair_q + 1'b1;
        end
      end
      TRAILS: begin
        if (ABORT || cnt_q == 4'd0) begin
          state_d = PARK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      PARK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    t_d    = 1'b1;
    ce_d   = 1'b0;
    d0_d   = 1'b0;
    d1_d   = 1'b0;
    dr_d   = 1'b0;
    ds_d   = 1'b0;
    busy_d = (state_d != IDLE);
    case (state_d)
      LEADS, TRAILS: begin
        t_d  = 1'b0;
        ce_d = 1'b1;
        d0_d = IDLE_LVL;
        d1_d = IDLE_LVL;
      end
      SHIFT: begin
        t_d  = 1'b0;
        ce_d = 1'b1;
        d0_d = sh_d[WIDTH-1];
        d1_d = sh_d[WIDTH-2];
      end
      PARK: begin
        dr_d = !IDLE_LVL;
        ds_d = IDLE_LVL;
      end
      default: ;
    endcase
  end

  assign T    = t_q;
  assign CE   = ce_q;
  assign D0   = d0_q;
  assign D1   = d1_q;
  assign DR   = dr_q;
  assign DS   = ds_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_ddr_out_sequencer.sv
// tb/tb_ddr_out_sequencer.sv - directed self-checking bench for ddr_out_sequencer
// Output vectors are {T,CE,D0,D1,DR,DS,READY,BUSY}.
module tb_ddr_out_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r;
  logic [7:0] a_din;
  logic       a_valid, a_ready, a_abort, a_busy, a_d0, a_d1, a_ce, a_dr, a_ds, a_t;
  logic [3:0] b_din;
  logic       b_valid, b_ready, b_abort, b_busy, b_d0, b_d1, b_ce, b_dr, b_ds, b_t;

  int tests = 0;
  int fails = 0;

  ddr_out_sequencer #(.WIDTH(8), .LEAD(1), .TRAIL(1), .IDLE_LVL(1'b0)) dut_a (
    .C(clk), .R(r), .DIN(a_din), .VALID(a_valid), .READY(a_ready), .ABORT(a_abort),
    .BUSY(a_busy), .D0(a_d0), .D1(a_d1), .CE(a_ce), .DR(a_dr), .DS(a_ds), .T(a_t)
  );

  ddr_out_sequencer #(.WIDTH(4), .LEAD(0), .TRAIL(0), .IDLE_LVL(1'b1)) dut_b (
    .C(clk), .R(r), .DIN(b_din), .VALID(b_valid), .READY(b_ready), .ABORT(b_abort),
    .BUSY(b_busy), .D0(b_d0), .D1(b_d1), .CE(b_ce), .DR(b_dr), .DS(b_ds), .T(b_t)
  );

  function automatic logic [7:0] obs_a();
    return {a_t, a_ce, a_d0, a_d1, a_dr, a_ds, a_ready, a_busy};
  endfunction

  function automatic logic [7:0] obs_b();
    return {b_t, b_ce, b_d0, b_d1, b_dr, b_ds, b_ready, b_busy};
  endfunction

  task automatic test_reset();
    r = 1'b1;
    a_valid = 1'b0; a_abort = 1'b0; a_din = '0;
    b_valid = 1'b0; b_abort = 1'b0; b_din = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (obs_a() !== 8'b1000_0010) begin
      fails++;
      $display("FAIL reset_a: got %b expected %b", obs_a(), 8'b1000_0010);
    end
    tests++;
    if (obs_b() !== 8'b1000_0010) begin
      fails++;
      $display("FAIL reset_b: got %b expected %b", obs_b(), 8'b1000_0010);
    end
    r = 1'b0;
  endtask

  task automatic test_idle_hold();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      tests++;
      if (obs_a() !== 8'b1000_0010) begin
        fails++;
        $display("FAIL idle_hold cycle %0d: got %b expected %b", k, obs_a(), 8'b1000_0010);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] exp [1:8];
    exp = '{8'b0100_0001, 8'b0110_0001, 8'b0110_0001, 8'b0101_0001,
            8'b0101_0011, 8'b0100_0001, 8'b1000_1001, 8'b1000_0010};
    @(negedge clk);
    a_din = 8'hA5; a_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      a_valid = 1'b0;
      tests++;
      if (obs_a() !== exp[k]) begin
        fails++;
        $display("FAIL single cycle %0d: got %b expected %b", k, obs_a(), exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [1:12];
    exp = '{8'b0100_0001, 8'b0110_0001, 8'b0110_0001, 8'b0101_0001,
            8'b0101_0011, 8'b0100_0001, 8'b0111_0001, 8'b0111_0001,
            8'b0100_0011, 8'b0100_0001, 8'b1000_1001, 8'b1000_0010};
    @(negedge clk);
    a_din = 8'hA5; a_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      tests++;
      if (obs_a() !== exp[k]) begin
        fails++;
        $display("FAIL back_to_back cycle %0d: got %b expected %b", k, obs_a(), exp[k]);
      end
      a_valid = (k == 5);
      a_din   = 8'h3C;
    end
    a_valid = 1'b0;
  endtask

  task automatic test_abort();
    logic [7:0] exp [1:5];
    exp = '{8'b0100_0001, 8'b0111_0001, 8'b0111_0001, 8'b1000_1001, 8'b1000_0010};
    @(negedge clk);
    a_din = 8'hFF; a_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      a_valid = 1'b0;
      tests++;
      if (obs_a() !== exp[k]) begin
        fails++;
        $display("FAIL abort cycle %0d: got %b expected %b", k, obs_a(), exp[k]);
      end
      a_abort = (k == 3);
    end
    a_abort = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp [1:12];
    exp = '{8'b0100_0001, 8'b0110_0001, 8'b0110_0001, 8'b1000_0010,
            8'b0100_0001, 8'b0100_0001, 8'b0111_0001, 8'b0111_0001,
            8'b0100_0011, 8'b0100_0001, 8'b1000_1001, 8'b1000_0010};
    @(negedge clk);
    a_din = 8'hA5; a_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      tests++;
      if (obs_a() !== exp[k]) begin
        fails++;
        $display("FAIL mid_reset cycle %0d: got %b expected %b", k, obs_a(), exp[k]);
      end
      r       = (k == 3);
      a_valid = (k == 3) || (k == 4);
      a_din   = 8'h3C;
    end
    r = 1'b0;
    a_valid = 1'b0;
  endtask

  task automatic test_variant();
    logic [7:0] exp [1:4];
    exp = '{8'b0110_0001, 8'b0101_0011, 8'b1000_0101, 8'b1000_0010};
    @(negedge clk);
    b_din = 4'h9; b_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      b_valid = 1'b0;
      tests++;
      if (obs_b() !== exp[k]) begin
        fails++;
        $display("FAIL variant cycle %0d: got %b expected %b", k, obs_b(), exp[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_single();
    test_back_to_back();
    test_abort();
    test_mid_reset();
    test_variant();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ddr_out_sequencer.md
Name: ddr_out_sequencer

Overview:
Sequences one DDR output pad cell: a dual-edge output flop with clock enable, sync set/reset and a tristate control. Accepts parallel words over a valid/ready handshake and drives the cell's D0/D1 pairs, CE, R, S and T. It frames each burst with lead and trail cycles and returns the pad to high-Z when idle. Sits between the transmit datapath and the pad cell; one instance per output pin.

Parameters:
WIDTH, 8, word width in bits; must be even and >= 2; PAIRS = WIDTH/2 cycles per word
LEAD, 1, cycles of driven idle level after T enables and before the first data pair (0..15)
TRAIL, 1, cycles of driven idle level after the last data pair before T releases (0..15)
IDLE_LVL, 1'b0, pad level driven during LEAD/TRAIL and parked into the cell on return to idle

Ports:
C  in  1  clock; all logic on rising edge
R  in  1  synchronous reset, active-high
DIN  in  WIDTH  word to transmit, MSB first
VALID  in  1  DIN valid
READY  out  1  word accepted on rising C when VALID&READY
ABORT  in  1  synchronous abort of current burst
BUSY  out  1  1 in any state other than IDLE
D0  out  1  to cell D0; bit sent in first half of cycle
D1  out  1  to cell D1; bit sent in second half of cycle
CE  out  1  to cell CE
DR  out  1  to cell sync reset
DS  out  1  to cell sync set
T  out  1  to cell tristate; 1 = high-Z

Behaviour:
- All outputs are registered except READY (decoded from state/counters).
- States: IDLE, LEADS, SHIFT, TRAILS, PARK.
- Reset (R=1 at edge): state IDLE. T=1, CE=0, D0=D1=0, DR=0, DS=0, BUSY=0. Counters and shift register are cleared. Reset overrides ABORT and VALID. Mid-burst reset discards the word; T=1 from the next cycle.
- IDLE: T=1, CE=0, READY=1. On accept, load DIN into the shift register and go to LEADS, or to SHIFT if LEAD=0.
- LEADS: T=0, CE=1, D0=D1=IDLE_LVL for exactly LEAD cycles. READY=0.
- SHIFT: T=0, CE=1. Cycle k (0..PAIRS-1) drives D0=word[WIDTH-1-2k] and D1=word[WIDTH-2-2k]. READY=1 only in the cycle presenting the last pair (k=PAIRS-1).
  - Accept in that cycle: reload and continue SHIFT with k=0 next cycle. No gap, no extra LEAD.
  - No accept: go to TRAILS, or to PARK if TRAIL=0.
- TRAILS: T=0, CE=1, D0=D1=IDLE_LVL for TRAIL cycles. READY=0. VALID is ignored.
- PARK: one cycle. T=1, CE=0, READY=0. Pulse DR=1 if IDLE_LVL=0, else DS=1. The other of DR/DS stays 0. Next state is IDLE.
- ABORT=1 in LEADS/SHIFT/TRAILS: go to PARK next cycle and discard the current word. No handshake completes that cycle (READY forced 0). ABORT in IDLE or PARK has no effect.
- DR and DS are never 1 simultaneously. DR/DS are 0 outside PARK.
- T=0 implies CE=1. CE=0 implies T=1.
- BUSY=1 in LEADS, SHIFT, TRAILS and PARK.
- Counters: lead/trail counter 4 bits; pair counter ceil(log2(PAIRS)) bits, wrapping 0..PAIRS-1.

Test Plan:
- WIDTH=8, LEAD=1, TRAIL=1, IDLE_LVL=0; DIN=8'hA5 accepted at edge 0 -> cycle 1: T=0, D0/D1=0/0; cycles 2–5: pairs (1,0),(1,0),(0,1),(0,1); cycle 6: trail 0/0; cycle 7: T=1, CE=0, DR=1; cycle 8: IDLE, READY=1.
- Back-to-back 8'hA5 then 8'h3C, second accepted in cycle 5 -> cycles 6–9: (0,0),(1,1),(1,1),(0,0); single LEAD and single TRAIL for the whole burst; READY high only in cycles 5 and 9 during the burst.
- VALID held 0 for 20 cycles after reset -> T=1, CE=0, BUSY=0, DR=DS=0 throughout.
- ABORT pulsed in the second SHIFT cycle of 8'hFF -> next cycle PARK (T=1, DR=1), then IDLE; no further data pairs emitted.
- R asserted mid-SHIFT with VALID=1 -> next cycle all outputs at reset values and no PARK pulse; after R drops, a new word is accepted normally.
- Parameter variant LEAD=0, TRAIL=0, IDLE_LVL=1, WIDTH=4, DIN=4'h9 -> cycles 1–2: (1,0),(0,1); cycle 3: PARK with DS=1, DR=0.
